// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 Set-2 scan code decoder: FSM states,
// prefix/control byte values and the Pong paddle key codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_W    = 8'h1D;
  localparam logic [7:0] KEY_S    = 8'h1B;
  localparam logic [7:0] KEY_UP   = 8'h75;
  localparam logic [7:0] KEY_DOWN = 8'h72;

  // Bytes following E1 that make up the rest of the Pause sequence.
  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  function automatic logic is_ctrl_code(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Inter-byte watchdog: counts while enabled, restarts on clear, and pulses
// o_expired on the cycle the count sits at TIMEOUT_CYCLES.
module ps2_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A clear on the expiry cycle means a byte arrived in time; it takes priority.
  assign o_expired = i_enable && !i_clear && (r_cnt == LIMIT);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 Set-2 byte sequences into key events and tracks paddle keys.
// Optional typematic-repeat suppression: define PS2_REPEAT_FILTER_EN.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic       left_up,
  output logic       left_down,
  output logic       right_up,
  output logic       right_down,
  output logic       seq_error
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_pause_cnt;
  logic [2:0] w_pause_nxt;

  logic       w_expired;
  logic       w_evt;
  logic [7:0] w_evt_code;
  logic       w_evt_ext;
  logic       w_evt_make;
  logic       w_seq_err;
  logic       w_repeat;

  logic       r_key_valid;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_make;
  logic       r_left_up;
  logic       r_left_down;
  logic       r_right_up;
  logic       r_right_down;
  logic       r_seq_error;

  ps2_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (rx_ready),
    .i_enable  (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pause_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_cnt <= w_pause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pause_nxt = r_pause_cnt;
    w_evt       = 1'b0;
    w_evt_code  = rx_data;
    w_evt_ext   = 1'b0;
    w_evt_make  = 1'b0;
    w_seq_err   = 1'b0;

    if (rx_ready) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (rx_data == SC_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (rx_data == SC_PAUSE) begin
            w_state_nxt = ST_PAUSE;
            w_pause_nxt = PAUSE_TAIL_LEN;
          end else if (!is_ctrl_code(rx_data)) begin
            w_evt      = 1'b1;
            w_evt_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else begin
            w_state_nxt = ST_IDLE;
            if (rx_data != SC_FAKE_SHIFT) begin
              w_evt      = 1'b1;
              w_evt_ext  = 1'b1;
              w_evt_make = 1'b1;
            end
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          w_evt       = (rx_data != SC_BRK) && (rx_data != SC_EXT);
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          w_evt       = (rx_data != SC_FAKE_SHIFT);
          w_evt_ext   = 1'b1;
        end
        ST_PAUSE: begin
          if (r_pause_cnt <= 3'd1) begin
            w_state_nxt = ST_IDLE;
            w_pause_nxt = '0;
            w_evt       = 1'b1;
            w_evt_code  = SC_PAUSE;
            w_evt_make  = 1'b1;
          end else begin
            w_pause_nxt = r_pause_cnt - 3'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expired) begin
      w_state_nxt = ST_IDLE;
      w_pause_nxt = '0;
      w_seq_err   = 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       r_last_valid;
  logic       r_last_ext;
  logic [7:0] r_last_code;
  logic       w_match_last;

  assign w_match_last = r_last_valid && (r_last_ext == w_evt_ext) &&
                        (r_last_code == w_evt_code);
  assign w_repeat     = w_evt && w_evt_make && w_match_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_valid <= 1'b0;
      r_last_ext   <= 1'b0;
      r_last_code  <= '0;
    end else if (w_evt) begin
      if (w_evt_make) begin
        r_last_valid <= 1'b1;
        r_last_ext   <= w_evt_ext;
        r_last_code  <= w_evt_code;
      end else if (w_match_last) begin
        r_last_valid <= 1'b0;
      end
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_valid  <= 1'b0;
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_key_make   <= 1'b0;
      r_left_up    <= 1'b0;
      r_left_down  <= 1'b0;
      r_right_up   <= 1'b0;
      r_right_down <= 1'b0;
      r_seq_error  <= 1'b0;
    end else begin
      r_key_valid <= w_evt && !w_repeat;
      r_seq_error <= w_seq_err;
      if (w_evt && !w_repeat) begin
        r_key_code <= w_evt_code;
        r_key_ext  <= w_evt_ext;
        r_key_make <= w_evt_make;
      end
      // Paddle flags follow every decoded event, including filtered repeats.
      if (w_evt) begin
        case ({w_evt_ext, w_evt_code})
          {1'b0, KEY_W}:    r_left_up    <= w_evt_make;
          {1'b0, KEY_S}:    r_left_down  <= w_evt_make;
          {1'b1, KEY_UP}:   r_right_up   <= w_evt_make;
          {1'b1, KEY_DOWN}: r_right_down <= w_evt_make;
          default: ;
        endcase
      end
    end
  end

  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_make   = r_key_make;
  assign left_up    = r_left_up;
  assign left_down  = r_left_down;
  assign right_up   = r_right_up;
  assign right_down = r_right_down;
  assign seq_error  = r_seq_error;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (short timeout).
module tb_ps2_scancode_decoder;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       left_up;
  logic       left_down;
  logic       right_up;
  logic       right_down;
  logic       seq_error;

  int tests = 0;
  int fails = 0;

  int         ev_cnt  = 0;
  int         err_cnt = 0;
  logic [7:0] ev_code = '0;
  logic       ev_ext  = 1'b0;
  logic       ev_make = 1'b0;
  int         base;
  int         base_err;
  int         exp_rep;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_make   (key_make),
    .left_up    (left_up),
    .left_down  (left_down),
    .right_up   (right_up),
    .right_down (right_down),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      ev_cnt  <= ev_cnt + 1;
      ev_code <= key_code;
      ev_ext  <= key_ext;
      ev_make <= key_make;
    end
    if (seq_error === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_event(input string tag, input int n, input logic [7:0] code,
                             input logic ext, input logic make);
    check({tag, "_count"}, ev_cnt - base, n);
    check({tag, "_code"}, ev_code, code);
    check({tag, "_ext"}, ev_ext, ext);
    check({tag, "_make"}, ev_make, make);
  endtask

  initial begin
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 8'h00);
    check("rst_flags", {left_up, left_down, right_up, right_down}, 4'b0000);
    check("rst_seqerr", seq_error, 1'b0);
    reset = 1'b0;
    settle();

    // W press / release
    base = ev_cnt;
    send_byte(8'h1D); settle();
    check_event("w_make", 1, 8'h1D, 1'b0, 1'b1);
    check("w_left_up1", left_up, 1'b1);
    base = ev_cnt;
    send_byte(8'hF0); send_byte(8'h1D); settle();
    check_event("w_brk", 1, 8'h1D, 1'b0, 1'b0);
    check("w_left_up0", left_up, 1'b0);

    // Up arrow press / release
    base = ev_cnt;
    send_byte(8'hE0); send_byte(8'h75); settle();
    check_event("up_make", 1, 8'h75, 1'b1, 1'b1);
    check("up_flag1", right_up, 1'b1);
    base = ev_cnt;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); settle();
    check_event("up_brk", 1, 8'h75, 1'b1, 1'b0);
    check("up_flag0", right_up, 1'b0);
    check("up_left", {left_up, left_down}, 2'b00);

    // Pause sequence
    base = ev_cnt;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    check("pause_mid", ev_cnt - base, 0);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77); settle();
    check_event("pause", 1, 8'hE1, 1'b0, 1'b1);

    // Timeout after dangling E0
    base     = ev_cnt;
    base_err = err_cnt;
    send_byte(8'hE0);
    for (int i = 0; i < 4 * TO && err_cnt == base_err; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("to_seqerr", err_cnt - base_err, 1);
    check("to_noevt", ev_cnt - base, 0);
    send_byte(8'h1B); settle();
    check_event("to_after", 1, 8'h1B, 1'b0, 1'b1);
    check("to_left_down", left_down, 1'b1);
    base = ev_cnt;
    send_byte(8'hF0); send_byte(8'h1B); settle();
    check("s_release", left_down, 1'b0);

    // Byte arriving exactly on the expiry cycle wins
    base     = ev_cnt;
    base_err = err_cnt;
    send_byte(8'hE0);
    repeat (TO) @(negedge clk);
    rx_data  = 8'h75;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    settle();
    check_event("edge", 1, 8'h75, 1'b1, 1'b1);
    check("edge_seqerr", err_cnt - base_err, 0);
    base = ev_cnt;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); settle();
    check("edge_rel", right_up, 1'b0);

    // Control bytes, fake shift, typematic repeat
    base = ev_cnt;
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hE0); send_byte(8'h12); settle();
    check("ctrl_noevt", ev_cnt - base, 0);
    send_byte(8'h1B); send_byte(8'h1B); send_byte(8'h1B); settle();
`ifdef PS2_REPEAT_FILTER_EN
    exp_rep = 1;
`else
    exp_rep = 3;
`endif
    check_event("rep", exp_rep, 8'h1B, 1'b0, 1'b1);
    check("rep_left_down", left_down, 1'b1);

    // Reset while keys are held
    send_byte(8'h1D); settle();
    check("rr_left_up1", left_up, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_flags", {left_up, left_down}, 2'b00);
    check("rr_valid", key_valid, 1'b0);
    reset = 1'b0;
    base = ev_cnt;
    send_byte(8'hF0); send_byte(8'h1D); settle();
    check_event("rr_brk", 1, 8'h1D, 1'b0, 1'b0);

    // Reset mid-sequence drops the pending E0
    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = ev_cnt;
    send_byte(8'h1B); settle();
    check_event("rm", 1, 8'h1B, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
